// File: rtl/des_expand_mix.sv
// DES round-function front end: E expansion of R, XOR with the round subkey, two-stage valid/ready pipe.
// Optional per-group parity (out_par, in_k_par, par_err) is compiled in with `define DES_MIX_PARITY_EN.
module des_expand_mix #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_r,
    input  logic [47:0]      in_k,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      out_mix,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      xfer_cnt
`ifdef DES_MIX_PARITY_EN
    ,
    input  logic [7:0]       in_k_par,
    output logic [7:0]       out_par,
    output logic             par_err
`endif
);

    // Group g feeds S-box g+1; each 4-bit nibble is flanked by its cyclic neighbours.
    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int g = 0; g < 8; g++) begin
            e[47-6*g -: 6] = {r[(32-4*g)%32], r[31-4*g -: 4], r[(59-4*g)%32]};
        end
        return e;
    endfunction

    function automatic logic [7:0] group_xor(input logic [47:0] x);
        logic [7:0] p;
        p = '0;
        for (int g = 0; g < 8; g++) begin
            p[7-g] = ^x[47-6*g -: 6];
        end
        return p;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_r_q;
    logic [47:0]      s1_k_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s2_valid_q, s2_valid_d;
    logic [47:0]      s2_mix_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    logic xfer, s2_load, accept, advance;

    assign xfer     = s2_valid_q && out_ready;
    assign s2_load  = !s2_valid_q || xfer;
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign advance  = s2_load && s1_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        xfer_cnt_d = xfer_cnt_q + {15'd0, xfer};
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (advance) begin
                s1_valid_d = 1'b0;
            end
            if (s2_load) begin
                s2_valid_d = s1_valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_r_q   <= in_r;
            s1_k_q   <= in_k;
            s1_tag_q <= in_tag;
        end
    end

    // Stage 2: expanded and key-mixed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_mix_q <= '0;
            s2_tag_q <= '0;
        end else if (advance) begin
            s2_mix_q <= expand(s1_r_q) ^ s1_k_q;
            s2_tag_q <= s1_tag_q;
        end
    end

`ifdef DES_MIX_PARITY_EN
    logic [7:0] s2_par_q;
    logic       par_err_q;
    logic       kpar_bad;

    // Each subkey group plus its parity bit must carry an odd number of ones.
    assign kpar_bad = ~&(group_xor(in_k) ^ in_k_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_par_q  <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (advance) begin
                s2_par_q <= group_xor(expand(s1_r_q) ^ s1_k_q);
            end
            if (accept && !flush && kpar_bad) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign out_par = s2_par_q;
    assign par_err = par_err_q;
`endif

    assign out_valid = s2_valid_q;
    assign out_mix   = s2_mix_q;
    assign out_tag   = s2_tag_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_des_expand_mix.sv
// Bench for des_expand_mix: directed vectors plus random valid/ready traffic against a queue model
// that derives E(R) from the standard DES E table.
module tb_des_expand_mix;
    localparam int TAG_W = 4;

    // DES E table, 1-based bit numbers with bit 1 = MSB.
    localparam int ETAB[48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                               12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                               24,25,26,27,28,29, 28,29,30,31,32, 1};

    logic             clk, rst_n;
    logic             in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]      in_r;
    logic [47:0]      in_k, out_mix;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [15:0]      xfer_cnt;
`ifdef DES_MIX_PARITY_EN
    logic [7:0]       in_k_par, out_par;
    logic             par_err;
    bit               kpar_flip;
`endif

    des_expand_mix #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_k(in_k), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mix(out_mix), .out_tag(out_tag),
        .xfer_cnt(xfer_cnt)
`ifdef DES_MIX_PARITY_EN
        , .in_k_par(in_k_par), .out_par(out_par), .par_err(par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [47:0]      mix;
        logic [TAG_W-1:0] tag;
        int               born;
    } item_t;

    item_t            q[$];
    int               vectors = 0;
    int               miscompares = 0;
    int               cyc_no = 0;
    int               cnt_exp = 0;
    bit               last_acc;
    bit               hold_pend = 0;
    logic [47:0]      hold_mix;
    logic [TAG_W-1:0] hold_tag;

    function automatic logic [47:0] ref_e(input logic [31:0] r);
        logic [47:0] e;
        for (int j = 1; j <= 48; j++) e[48-j] = r[32-ETAB[j-1]];
        return e;
    endfunction

    function automatic logic [7:0] gxor(input logic [47:0] m);
        logic [7:0] p;
        p = '0;
        for (int b = 0; b < 48; b++) p[7-b/6] = p[7-b/6] ^ m[47-b];
        return p;
    endfunction

    function automatic logic [47:0] rnd48();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return x[47:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, then step past the next edge.
    task automatic drive(input bit v, input logic [31:0] r, input logic [47:0] k,
                         input logic [TAG_W-1:0] t, input bit ordy, input bit fl);
        bit    exp_ov, exp_rdy;
        item_t it;
        in_valid = v; in_r = r; in_k = k; in_tag = t; out_ready = ordy; flush = fl;
`ifdef DES_MIX_PARITY_EN
        in_k_par = ~gxor(k) ^ (kpar_flip ? 8'h10 : 8'h00);
`endif
        #1;
        exp_ov  = (q.size() > 0) && (cyc_no - q[0].born >= 2);
        exp_rdy = (q.size() < 2) || ordy;
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check("xfer_cnt", 64'(xfer_cnt), 64'(cnt_exp[15:0]));
        if (hold_pend) begin
            check("hold_mix", 64'(out_mix), 64'(hold_mix));
            check("hold_tag", 64'(out_tag), 64'(hold_tag));
        end
        hold_pend = exp_ov && !ordy && !fl;
        if (hold_pend) begin
            hold_mix = q[0].mix;
            hold_tag = q[0].tag;
        end
        if (exp_ov && ordy) begin
            it = q.pop_front();
            check("out_mix", 64'(out_mix), 64'(it.mix));
            check("out_tag", 64'(out_tag), 64'(it.tag));
`ifdef DES_MIX_PARITY_EN
            check("out_par", 64'(out_par), 64'(gxor(it.mix)));
`endif
            cnt_exp++;
        end
        last_acc = v && exp_rdy;
        if (fl) begin
            q.delete();
        end else if (last_acc) begin
            it.mix = ref_e(r) ^ k;
            it.tag = t;
            it.born = cyc_no;
            q.push_back(it);
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 32'd0, 48'd0, '0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        int acc_stall, sent, guard;
        rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_k = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;
`ifdef DES_MIX_PARITY_EN
        in_k_par = '0; kpar_flip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_mix", 64'(out_mix), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        rst_n = 1'b1;
        idle(1'b1);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Standard DES round-1 vector
        drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd1, 1'b0, 1'b0);
        idle(1'b0);
        check("std_mix", 64'(out_mix), 64'h6117BA866527);
        check("std_s8", 64'(out_mix[5:0]), 64'h27);
        check("std_tag", 64'(out_tag), 64'd1);
        drain();

        // Wrap-around bits of the expansion
        drive(1'b1, 32'h80000001, 48'd0, 4'd2, 1'b0, 1'b0);
        idle(1'b0);
        check("wrap_mix", 64'(out_mix), 64'hC00000000003);
        drain();
        drive(1'b1, 32'hFFFFFFFF, 48'd0, 4'd3, 1'b0, 1'b0);
        idle(1'b0);
        check("ones_mix", 64'(out_mix), 64'hFFFFFFFFFFFF);
        drain();

        // Flush with both stages full and a new request in the same cycle
        drive(1'b1, $urandom, rnd48(), 4'd7, 1'b0, 1'b0);
        drive(1'b1, $urandom, rnd48(), 4'd8, 1'b0, 1'b0);
        drive(1'b1, $urandom, rnd48(), 4'd9, 1'b0, 1'b1);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_ready", {63'd0, in_ready}, 64'd1);
        repeat (4) idle(1'b1);

        // Asynchronous reset with both stages full
        drive(1'b1, $urandom, rnd48(), 4'd4, 1'b0, 1'b0);
        drive(1'b1, $urandom, rnd48(), 4'd5, 1'b0, 1'b0);
        idle(1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_out_mix", 64'(out_mix), 64'd0);
        check("mrst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        q.delete(); cnt_exp = 0; hold_pend = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_no++;
        check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (4) idle(1'b1);

        // Backpressure: tags 0..5 with out_ready low for the first 4 cycles
        acc_stall = 0; sent = 0; guard = 0;
        while (sent < 6 && guard < 40) begin
            drive(1'b1, $urandom, rnd48(), sent[TAG_W-1:0], guard >= 4, 1'b0);
            if (last_acc) begin
                if (guard < 4) acc_stall++;
                sent++;
            end
            guard++;
        end
        check("bp_sent", 64'(sent), 64'd6);
        check("bp_stall_accepts", 64'(acc_stall), 64'd2);
        drain();
        check("bp_xfer_cnt", 64'(xfer_cnt), 64'd6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, rnd48(), TAG_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        drain();

`ifdef DES_MIX_PARITY_EN
        check("par_err_clean", {63'd0, par_err}, 64'd0);
        kpar_flip = 1'b1;
        drive(1'b1, $urandom, rnd48(), 4'd3, 1'b1, 1'b0);
        kpar_flip = 1'b0;
        check("par_err_set", {63'd0, par_err}, 64'd1);
        repeat (3) idle(1'b1);
        check("par_err_sticky", {63'd0, par_err}, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/des_expand_mix.md
# des_expand_mix

Pipelined expansion/key-mix stage of the DES round function. Accepts the 32-bit right half and the 48-bit round subkey, applies the E expansion, XORs in the subkey, and presents the 48-bit result as eight 6-bit S-box inputs. The S1..S8 lookup bank sits directly downstream, with S8 taking the least-significant group. A two-register valid/ready pipeline decouples the round controller from the S-box/P-permutation stage.

## Interface
Parameters:
- TAG_W, default 4, width of the sideband tag carried with each transaction (round index).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream holds a transaction.
- in_ready  output  1  block accepts when in_valid && in_ready.
- in_r  input  32  right half R; in_r[31] is DES bit 1.
- in_k  input  48  subkey; in_k[47] is DES bit 1.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- flush  input  1  synchronous clear of both stages.
- out_valid  output  1  mix result available.
- out_ready  input  1  downstream consumes when out_valid && out_ready.
- out_mix  output  48  E(R) XOR K; S1 gets [47:42] … S8 gets [5:0].
- out_tag  output  TAG_W  tag of the transaction on out_mix.
- xfer_cnt  output  16  count of completed output transfers, wraps at 0xFFFF→0.

## Operation
- Stage 1 (S1 reg): captures in_r, in_k, in_tag on accept.
- Stage 2 (S2 reg): captures mix = E(S1.r) ^ S1.k and S1.tag.
- Expansion, group g = 0..7 (g=0 → S1): {r[(32-4g)%32], r[31-4g:28-4g], r[(59-4g)%32]}. Placed at mix[47-6g -: 6]. Group 0 is {r[0], r[31:28], r[27]}. Group 7 is {r[4], r[3:0], r[31]}.
- S2 loads when !s2_valid or (out_valid && out_ready).
- S1 advances into S2 whenever S2 loads and s1_valid.
- in_ready = !s1_valid || s2_load. This is combinational, so back-to-back accepts give full throughput.
- Simultaneous accept and S1→S2 advance in the same cycle: S1 takes the new data and S2 takes the old S1 data. Neither is lost or duplicated.
- out_ready low: S2 holds out_mix/out_tag stable. S1 then fills, and in_ready drops only when both stages are full.
- flush: next edge clears s1_valid and s2_valid. Any accept in the flush cycle is discarded. xfer_cnt is not cleared.
- xfer_cnt increments on each out_valid && out_ready.
- Reset (async assert, synchronous deassert expected from the system): s1_valid = s2_valid = 0, out_valid = 0, out_mix = 0, out_tag = 0, xfer_cnt = 0. in_ready reads 1 while reset is deasserted and the pipe is empty.
- Reset mid-transaction: all in-flight data is dropped. No output after release until a new accept.

## Timing
- Latency: accept at edge N → out_valid high after edge N+2 (two registers), when not stalled.
- Throughput: one transaction per cycle when out_ready stays high.
- out_valid, out_mix and out_tag are registered. in_ready is a combinational function of state and out_ready.
- Once out_valid is asserted, it stays high with stable data until the transfer completes or flush/reset occurs.

## Configuration
- DES_MIX_PARITY_EN defined:
  - Adds output out_par[7:0], registered alongside out_mix.
  - out_par[7-g] = ^mix group g (even-parity bit per S-box input; bit 7 ↔ S1).
  - Adds input in_k_par[7:0]: odd parity over each 6-bit subkey group.
  - Adds output par_err, a sticky flag set when an accepted in_k group fails odd parity. Cleared only by reset.
- DES_MIX_PARITY_EN undefined: none of these ports or registers exist. Behaviour is otherwise identical.

## Test plan
- Reset: rst_n low mid-stream with both stages full → out_valid=0, out_mix=0, xfer_cnt=0 immediately. After release, in_ready=1.
- Standard vector: in_r=0xF0AAF0AA, in_k=0x1B02EFFC7072, tag=1 → two cycles later out_mix=0x6117BA866527 (S8 group 0x27), out_tag=1.
- Wrap bits: in_r=0x80000001, in_k=0 → out_mix=0xC00000000003. Also in_r=0xFFFFFFFF, in_k=0 → 0xFFFFFFFFFFFF.
- Backpressure: stream tags 0..5 with out_ready low for 4 cycles → in_ready drops after 2 accepts. Outputs then appear in order 0..5 with no loss, and xfer_cnt=6.
- Flush with both stages full and in_valid high in the same cycle → next cycle out_valid=0, in_ready=1, and no stale output thereafter.
- With DES_MIX_PARITY_EN, in_k_par with group 3 wrong → par_err=1 one cycle after accept and stays set. out_par matches per-group XOR of out_mix.
